cam_line_sched: RTL and testbench

- PCLK-domain capture sequencer for the camera line-buffer write path.
- Arms on request, waits for frame start (CamVsync falling), skips to a configured start line, then captures a window of lines.
- Ping-pongs between two line-buffer banks, with per-bank ready/ack handshake to the downstream reader.
- Gates pixel writes (CAP_EN) and drops lines when the target bank is still owned by the reader.

---
 rtl/cam_line_sched.sv | 156 +++++++++++++++
 tb/tb_cam_line_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_line_sched.sv
// Camera line-capture sequencer: arm, sync to frame start, skip to window, ping-pong two line banks.
// CAP_EN follows CamHsync combinationally; a line is dropped when its bank is still held. Option: CAM_LINE_DECIM_EN (2:1 vertical decimation).
module cam_line_sched #(
   parameter int LINE_W = 9
) (
   input  logic              PCLK,
   input  logic              RST_N,
   input  logic              CamHsync,
   input  logic              CamVsync,
   input  logic              ARM,
   input  logic              CONT,
   input  logic              ABORT,
   input  logic [LINE_W-1:0] CFG_START_LINE,
   input  logic [LINE_W-1:0] CFG_NUM_LINES,
   input  logic [1:0]        LINE_ACK,
   output logic              CAP_EN,
   output logic              WR_BANK,
   output logic [1:0]        LINE_RDY,
   output logic [LINE_W-1:0] LINE_IDX,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic              OVERFLOW,
   output logic              TRUNC
);

   typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, ACTIVE} state_t;

   state_t            state, stateNext;
   logic              hsD, vsD;
   logic              hsRise, hsFall, vsFall;
   logic [LINE_W-1:0] startLine, numLines, frameLine, lineIdx;
   logic [LINE_W-1:0] lineIdxInc, frameLineInc;
   logic              contMode, lineOk, wrBank;
   logic [1:0]        lineRdy, rdySet;
   logic              frameDone, overflow, trunc;
   logic              armOk, inWindow, frameEnd, restart, winEnd, skipEnd, activeEdge;
   logic              lineEligible;

   assign hsRise       = CamHsync & ~hsD;
   assign hsFall       = ~CamHsync & hsD;
   assign vsFall       = ~CamVsync & vsD;
   assign lineIdxInc   = lineIdx + LINE_W'(1);
   assign frameLineInc = frameLine + LINE_W'(1);

`ifdef CAM_LINE_DECIM_EN
   assign lineEligible = ~lineIdx[0];
`else
   assign lineEligible = 1'b1;
`endif

   // Frame-boundary vsync outranks line edges; ABORT outranks everything.
   assign armOk      = ~ABORT & (state == IDLE) & ARM & (CFG_NUM_LINES != '0);
   assign inWindow   = (state == SKIP) | (state == ACTIVE);
   assign frameEnd   = ~ABORT & inWindow & vsFall;
   assign restart    = (~ABORT & (state == WAIT_VS) & vsFall) | (frameEnd & contMode);
   assign activeEdge = ~ABORT & (state == ACTIVE) & ~vsFall;
   assign winEnd     = activeEdge & hsFall & (lineIdxInc == numLines);
   assign skipEnd    = ~ABORT & (state == SKIP) & ~vsFall & hsFall & (frameLineInc == startLine);
   assign rdySet     = (activeEdge & hsFall & lineOk) ? (wrBank ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      if (ABORT) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE:    if (armOk) stateNext = WAIT_VS;
            WAIT_VS: if (vsFall) stateNext = (startLine == '0) ? ACTIVE : SKIP;
            SKIP, ACTIVE: begin
               if (vsFall) begin
                  if (contMode) stateNext = (startLine == '0) ? ACTIVE : SKIP;
                  else          stateNext = IDLE;
               end else if (skipEnd) begin
                  stateNext = ACTIVE;
               end else if (winEnd) begin
                  stateNext = contMode ? WAIT_VS : IDLE;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_comb begin
      BUSY   = (state != IDLE);
      CAP_EN = CamHsync & lineOk & (state == ACTIVE);
   end

   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         hsD       <= 1'b0;
         vsD       <= 1'b0;
         startLine <= '0;
         numLines  <= '0;
         frameLine <= '0;
         lineIdx   <= '0;
         contMode  <= 1'b0;
         lineOk    <= 1'b0;
         wrBank    <= 1'b0;
         lineRdy   <= 2'b00;
         frameDone <= 1'b0;
         overflow  <= 1'b0;
         trunc     <= 1'b0;
      end else begin
         hsD       <= CamHsync;
         vsD       <= CamVsync;
         frameDone <= 1'b0;
         lineRdy   <= (lineRdy & ~LINE_ACK) | rdySet;
         if (ABORT) begin
            lineOk <= 1'b0;
         end else begin
            if (armOk) begin
               startLine <= CFG_START_LINE;
               numLines  <= CFG_NUM_LINES;
               contMode  <= CONT;
               overflow  <= 1'b0;
               trunc     <= 1'b0;
            end
            if (restart) begin
               frameLine <= '0;
               lineIdx   <= '0;
               lineOk    <= 1'b0;
            end
            if (frameEnd) begin
               trunc     <= 1'b1;
               frameDone <= 1'b1;
               lineOk    <= 1'b0;
            end
            if ((state == SKIP) & ~vsFall & hsFall) frameLine <= frameLineInc;
            if (activeEdge & hsRise) begin
               lineOk <= lineEligible & ~lineRdy[wrBank];
               if (lineEligible & lineRdy[wrBank]) overflow <= 1'b1;
            end
            if (activeEdge & hsFall) begin
               if (lineOk) wrBank <= ~wrBank;
               lineIdx <= lineIdxInc;
               lineOk  <= 1'b0;
               if (winEnd) frameDone <= 1'b1;
            end
         end
      end
   end

   assign WR_BANK    = wrBank;
   assign LINE_RDY   = lineRdy;
   assign LINE_IDX   = lineIdx;
   assign FRAME_DONE = frameDone;
   assign OVERFLOW   = overflow;
   assign TRUNC      = trunc;

endmodule

// File: tb/tb_cam_line_sched.sv
// Directed bench for cam_line_sched: table of single-frame scenarios plus hand sequences for truncation, abort and reset.
module tb_cam_line_sched;

   localparam int LINE_W = 9;

   logic              PCLK, RST_N, CamHsync, CamVsync, ARM, CONT, ABORT;
   logic [LINE_W-1:0] CFG_START_LINE, CFG_NUM_LINES;
   logic [1:0]        LINE_ACK;
   logic              CAP_EN, WR_BANK, BUSY, FRAME_DONE, OVERFLOW, TRUNC;
   logic [1:0]        LINE_RDY;
   logic [LINE_W-1:0] LINE_IDX;

   cam_line_sched #(.LINE_W(LINE_W)) dut (
      .PCLK(PCLK), .RST_N(RST_N), .CamHsync(CamHsync), .CamVsync(CamVsync),
      .ARM(ARM), .CONT(CONT), .ABORT(ABORT),
      .CFG_START_LINE(CFG_START_LINE), .CFG_NUM_LINES(CFG_NUM_LINES),
      .LINE_ACK(LINE_ACK), .CAP_EN(CAP_EN), .WR_BANK(WR_BANK), .LINE_RDY(LINE_RDY),
      .LINE_IDX(LINE_IDX), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
      .OVERFLOW(OVERFLOW), .TRUNC(TRUNC)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      int cont, start, num, ack, nLines;
      int expCap, expRdyCnt, expSeq, expOvf, expWrBank, expRdy;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, fallMark = -1, markLine = -1, rawLine = 15;
   int   fdCount = 0, fdCycle = -1, rdyCnt = 0;
   logic [15:0] capMask = '0;
   logic [7:0]  rdySeq = '0;
   logic [1:0]  prevRdy = '0;
   logic        ackEn = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Sample outputs on the falling edge, then drive the reader ack just after the rising edge.
   task automatic tick();
      @(negedge PCLK);
      if (CAP_EN) capMask[rawLine] = 1'b1;
      for (int b = 0; b < 2; b++)
         if (LINE_RDY[b] && !prevRdy[b]) begin
            rdySeq[rdyCnt] = b[0];
            rdyCnt++;
         end
      if (FRAME_DONE) begin
         fdCount++;
         fdCycle = cyc;
      end
      prevRdy = LINE_RDY;
      cyc++;
      @(posedge PCLK);
      #1;
      LINE_ACK = ackEn ? LINE_RDY : 2'b00;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clearMon();
      capMask = '0; rdySeq = '0; rdyCnt = 0; fdCount = 0; fdCycle = -1; fallMark = -1;
   endtask

   task automatic doReset();
      RST_N = 1'b0; CamHsync = 1'b0; CamVsync = 1'b0; ARM = 1'b0; CONT = 1'b0; ABORT = 1'b0;
      CFG_START_LINE = '0; CFG_NUM_LINES = '0; LINE_ACK = 2'b00; ackEn = 1'b0;
      ticks(2);
      RST_N = 1'b1;
      tick();
      prevRdy = 2'b00;
      clearMon();
   endtask

   task automatic doArm(input int cont, input int start, input int num);
      ARM = 1'b1; CONT = cont[0];
      CFG_START_LINE = start[LINE_W-1:0]; CFG_NUM_LINES = num[LINE_W-1:0];
      tick();
      ARM = 1'b0;
      tick();
   endtask

   task automatic oneLine(input int k);
      rawLine = k;
      CamHsync = 1'b1;
      ticks(4);
      CamHsync = 1'b0;
      if (k == markLine) fallMark = cyc;
      ticks(3);
      rawLine = 15;
   endtask

   task automatic frame(input int n);
      CamVsync = 1'b1;
      ticks(2);
      CamVsync = 1'b0;
      ticks(3);
      for (int k = 0; k < n; k++) oneLine(k);
   endtask

   initial begin
      vec_t v;
`ifdef CAM_LINE_DECIM_EN
      vecs.push_back('{cont:0, start:0, num:6, ack:1, nLines:6, expCap:'h15, expRdyCnt:3, expSeq:2, expOvf:0, expWrBank:1, expRdy:0});
`else
      vecs.push_back('{cont:0, start:2, num:3, ack:1, nLines:6, expCap:'h1C, expRdyCnt:3, expSeq:2, expOvf:0, expWrBank:1, expRdy:0});
      vecs.push_back('{cont:0, start:2, num:3, ack:0, nLines:6, expCap:'h0C, expRdyCnt:2, expSeq:2, expOvf:1, expWrBank:0, expRdy:3});
      vecs.push_back('{cont:0, start:0, num:2, ack:1, nLines:4, expCap:'h03, expRdyCnt:2, expSeq:2, expOvf:0, expWrBank:0, expRdy:0});
      vecs.push_back('{cont:0, start:1, num:4, ack:1, nLines:6, expCap:'h1E, expRdyCnt:4, expSeq:'hA, expOvf:0, expWrBank:0, expRdy:0});
      vecs.push_back('{cont:0, start:0, num:3, ack:0, nLines:4, expCap:'h03, expRdyCnt:2, expSeq:2, expOvf:1, expWrBank:0, expRdy:3});
`endif

      for (int r = 0; r < vecs.size(); r++) begin
         v = vecs[r];
         doReset();
         chk($sformatf("r%0d_reset_flags", r), {CAP_EN, BUSY, LINE_RDY, WR_BANK, OVERFLOW, TRUNC, FRAME_DONE}, 0);
         chk($sformatf("r%0d_reset_idx", r), LINE_IDX, 0);
         ackEn = v.ack[0];
         doArm(v.cont, v.start, v.num);
         chk($sformatf("r%0d_busy_armed", r), BUSY, 1);
         markLine = v.start + v.num - 1;
         frame(v.nLines);
         ticks(4);
         chk($sformatf("r%0d_cap_lines", r), capMask, v.expCap);
         chk($sformatf("r%0d_rdy_count", r), rdyCnt, v.expRdyCnt);
         chk($sformatf("r%0d_rdy_banks", r), rdySeq, v.expSeq);
         chk($sformatf("r%0d_overflow", r), OVERFLOW, v.expOvf);
         chk($sformatf("r%0d_trunc", r), TRUNC, 0);
         chk($sformatf("r%0d_fd_count", r), fdCount, 1);
         chk($sformatf("r%0d_fd_cycle", r), fdCycle, fallMark + 1);
         chk($sformatf("r%0d_busy_end", r), BUSY, 0);
         chk($sformatf("r%0d_wr_bank", r), WR_BANK, v.expWrBank);
         chk($sformatf("r%0d_line_rdy", r), LINE_RDY, v.expRdy);
      end

`ifndef CAM_LINE_DECIM_EN
      // Continuous mode, frame cut short after two window lines, then recapture.
      doReset();
      markLine = -1;
      ackEn = 1'b1;
      doArm(1, 0, 4);
      frame(2);
      chk("trunc_pre_lines", capMask, 'h3);
      CamVsync = 1'b1;
      ticks(2);
      CamVsync = 1'b0;
      ticks(2);
      chk("trunc_flag", TRUNC, 1);
      chk("trunc_fd", fdCount, 1);
      chk("trunc_busy", BUSY, 1);
      chk("trunc_idx_restart", LINE_IDX, 0);
      CamHsync = 1'b1;
      ticks(2);
      chk("trunc_recap_en", CAP_EN, 1);
      chk("trunc_recap_idx", LINE_IDX, 0);
      CamHsync = 1'b0;
      ticks(3);
      chk("trunc_idx_next", LINE_IDX, 1);
      CamHsync = 1'b1;
      ticks(2);
      chk("rst_pre_cap", CAP_EN, 1);
      RST_N = 1'b0;
      #1;
      chk("rst_async_cap", CAP_EN, 0);
      chk("rst_async_busy", BUSY, 0);
      CamHsync = 1'b0;
      RST_N = 1'b1;
      tick();

      // Abort in the middle of a captured line.
      doReset();
      doArm(0, 0, 4);
      frame(1);
      chk("abort_first_stored", LINE_RDY, 2'b01);
      CamHsync = 1'b1;
      ticks(2);
      chk("abort_pre_cap", CAP_EN, 1);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk("abort_cap", CAP_EN, 0);
      chk("abort_busy", BUSY, 0);
      chk("abort_rdy", LINE_RDY, 2'b01);
      CamHsync = 1'b0;
      ticks(3);
      chk("abort_rdy_after", LINE_RDY, 2'b01);
      chk("abort_no_fd", fdCount, 0);
      chk("abort_wr_bank", WR_BANK, 1);

      // Zero-height arm is ignored; a start-0 arm captures from the first line.
      doReset();
      doArm(0, 0, 0);
      tick();
      chk("num0_busy", BUSY, 0);
      doArm(0, 0, 1);
      chk("num1_busy", BUSY, 1);
      markLine = 0;
      frame(2);
      ticks(3);
      chk("num1_cap", capMask, 'h1);
      chk("num1_fd", fdCount, 1);
      chk("num1_fd_cycle", fdCycle, fallMark + 1);
      chk("num1_busy_end", BUSY, 0);
      chk("num1_rdy", LINE_RDY, 2'b01);
      chk("num1_trunc", TRUNC, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
